// File: rtl/explosion_tracker.sv
// Tracks up to DEPTH timed plus-shaped explosions and reports, per VGA pixel,
// whether it is covered and in which colour, plus a bomberman hit flag.
module explosion_tracker #(
  parameter int DEPTH    = 4,
  parameter int TILE     = 32,
  parameter int LIFETIME = 50_000_000
) (
  input  logic        sys_clk,
  input  logic        Reset,
  input  logic        wr_en,
  input  logic [9:0]  wr_x,
  input  logic [9:0]  wr_y,
  input  logic [9:0]  v_x,
  input  logic [9:0]  v_y,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  output logic        explosion_on,
  output logic [11:0] rgb_out,
  output logic        bomberman_hit,
  output logic [2:0]  active_count,
  output logic        overflow
);

  localparam int CW = (LIFETIME > 2) ? $clog2(LIFETIME) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LIFETIME - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(LIFETIME / 2);
  // One bit of headroom above the 11-bit signed range so x+2*TILE cannot
  // wrap negative at the right/bottom screen edge.
  localparam logic signed [11:0] T1 = 12'(TILE);
  localparam logic signed [11:0] T2 = 12'(2 * TILE);

  logic [DEPTH-1:0] slot_valid;
  logic [9:0]       slot_x   [DEPTH];
  logic [9:0]       slot_y   [DEPTH];
  logic [CW-1:0]    slot_cnt [DEPTH];

  logic [DEPTH-1:0] hit_match, slot_free, pix_cover, bm_cover;
  logic [IW-1:0]    match_idx, free_idx;
  logic             any_match, any_free;
  logic             sel_yellow;
  logic [2:0]       valid_pop;

  function automatic logic in_region(input logic [9:0] sx, input logic [9:0] sy,
                                     input logic [9:0] px, input logic [9:0] py);
    logic signed [11:0] x, y, u, v;
    logic h_arm, v_arm;
    x = $signed({2'b00, sx});
    y = $signed({2'b00, sy});
    u = $signed({2'b00, px});
    v = $signed({2'b00, py});
    h_arm = (u >= x - T1) && (u < x + T2) && (v >= y) && (v < y + T1);
    v_arm = (u >= x) && (u < x + T1) && (v >= y - T1) && (v < y + T2);
    return h_arm || v_arm;
  endfunction

  always_comb begin
    any_match  = 1'b0;
    any_free   = 1'b0;
    match_idx  = '0;
    free_idx   = '0;
    sel_yellow = 1'b0;
    valid_pop  = '0;
    hit_match  = '0;
    slot_free  = '0;
    pix_cover  = '0;
    bm_cover   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_match[i] = slot_valid[i] && (slot_x[i] == wr_x) && (slot_y[i] == wr_y);
      // A slot on its last cycle is reusable: the write overrides its expiry.
      slot_free[i] = !slot_valid[i] || (slot_cnt[i] == '0);
      pix_cover[i] = slot_valid[i] && in_region(slot_x[i], slot_y[i], v_x, v_y);
      bm_cover[i]  = slot_valid[i] && in_region(slot_x[i], slot_y[i], b_x, b_y);
      valid_pop    = valid_pop + 3'(slot_valid[i]);
    end
    // Descending scan so the lowest index wins.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit_match[i]) begin
        any_match = 1'b1;
        match_idx = IW'(i);
      end
      if (slot_free[i]) begin
        any_free = 1'b1;
        free_idx = IW'(i);
      end
      if (pix_cover[i]) sel_yellow = (slot_cnt[i] >= CNT_HALF);
    end
  end

  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      slot_valid    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_x[i]   <= '0;
        slot_y[i]   <= '0;
        slot_cnt[i] <= '0;
      end
      explosion_on  <= 1'b0;
      rgb_out       <= 12'h000;
      bomberman_hit <= 1'b0;
      active_count  <= '0;
      overflow      <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_valid[i]) begin
          if (slot_cnt[i] == '0) slot_valid[i] <= 1'b0;
          else                   slot_cnt[i]   <= slot_cnt[i] - 1'b1;
        end
      end
      if (wr_en) begin
        if (any_match) begin
          slot_valid[match_idx] <= 1'b1;
          slot_cnt[match_idx]   <= CNT_INIT;
        end else if (any_free) begin
          slot_valid[free_idx] <= 1'b1;
          slot_x[free_idx]     <= wr_x;
          slot_y[free_idx]     <= wr_y;
          slot_cnt[free_idx]   <= CNT_INIT;
        end else begin
          overflow <= 1'b1;
        end
      end
      active_count  <= valid_pop;
      explosion_on  <= |pix_cover;
      rgb_out       <= !(|pix_cover) ? 12'h000 : (sel_yellow ? 12'hFF0 : 12'hF00);
      bomberman_hit <= |bm_cover;
    end
  end

endmodule

// File: tb/tb_explosion_tracker.sv
// Directed bench for explosion_tracker with LIFETIME=8, TILE=32, DEPTH=4.
module tb_explosion_tracker;
  logic        sys_clk, Reset, wr_en;
  logic [9:0]  wr_x, wr_y, v_x, v_y, b_x, b_y;
  logic        explosion_on, bomberman_hit, overflow;
  logic [11:0] rgb_out;
  logic [2:0]  active_count;
  int checks = 0;
  int errors = 0;

  explosion_tracker #(.DEPTH(4), .TILE(32), .LIFETIME(8)) dut (
    .sys_clk(sys_clk), .Reset(Reset), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .v_x(v_x), .v_y(v_y), .b_x(b_x), .b_y(b_y), .explosion_on(explosion_on),
    .rgb_out(rgb_out), .bomberman_hit(bomberman_hit), .active_count(active_count),
    .overflow(overflow)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic en, input logic [9:0] x, input logic [9:0] y);
    wr_en = en; wr_x = x; wr_y = y;
  endtask

  initial begin
    Reset = 1'b1;
    wr(0, 0, 0);
    v_x = 0; v_y = 0; b_x = 0; b_y = 0;
    step;
    chk("rst_on", explosion_on, 0);
    chk("rst_rgb", rgb_out, 12'h000);
    chk("rst_hit", bomberman_hit, 0);
    chk("rst_ac", active_count, 0);
    chk("rst_ovf", overflow, 0);
    Reset = 1'b0;
    step;

    // Single explosion: display, colour phases, expiry
    wr(1, 64, 64); step;            // E0
    wr(0, 0, 0);
    chk("a_ac_lag", active_count, 0);
    v_x = 40; v_y = 70; step;       // E1
    chk("a_on_arm", explosion_on, 1);
    chk("a_rgb_yel", rgb_out, 12'hFF0);
    chk("a_ac1", active_count, 1);
    v_x = 40; v_y = 40; step;       // E2
    chk("a_off_corner", explosion_on, 0);
    chk("a_rgb_off", rgb_out, 12'h000);
    v_x = 70; v_y = 70; step(2);    // E4 samples counter 4
    chk("a_rgb_half", rgb_out, 12'hFF0);
    step;                           // E5 samples counter 3
    chk("a_rgb_red", rgb_out, 12'hF00);
    step(3);                        // E8 samples counter 0
    chk("a_on_last", explosion_on, 1);
    chk("a_ac_last", active_count, 1);
    step;                           // E9
    chk("a_on_gone", explosion_on, 0);
    chk("a_ac_gone", active_count, 0);
    chk("a_rgb_gone", rgb_out, 12'h000);

    // Bomberman hit and rewrite extension
    wr(1, 64, 64); b_x = 96; b_y = 64; step;   // E0
    wr(0, 0, 0); step;                          // E1
    chk("b_hit", bomberman_hit, 1);
    b_x = 96; b_y = 96; step;                   // E2
    chk("b_nohit", bomberman_hit, 0);
    step(2);                                    // E4
    wr(1, 64, 64); step;                        // E5 rewrite
    wr(0, 0, 0); step;                          // E6
    chk("b_ac_rewrite", active_count, 1);
    v_x = 70; v_y = 70; step(3);                // E9
    chk("b_on_extended", explosion_on, 1);
    step(4);                                    // E13
    chk("b_on_end", explosion_on, 1);
    chk("b_rgb_end", rgb_out, 12'hF00);
    step;                                       // E14
    chk("b_on_gone", explosion_on, 0);
    chk("b_ac_gone", active_count, 0);

    // Fill all slots, overflow, no wrap, expiry reuse, priority
    wr(1, 0, 0);   step;            // E0
    wr(1, 32, 0);  step;            // E1
    wr(1, 64, 0);  step;            // E2
    wr(1, 96, 0);  step;            // E3
    wr(1, 128, 0); step;            // E4 dropped
    wr(0, 0, 0);
    chk("c_ovf", overflow, 1);
    v_x = 140; v_y = 40; step;      // E5
    chk("c_dropped_hidden", explosion_on, 0);
    chk("c_ac4", active_count, 4);
    v_x = 5; v_y = 1000; step;      // E6
    chk("c_nowrap", explosion_on, 0);
    v_x = 5; v_y = 5; step;         // E7
    chk("c_on_slot0", explosion_on, 1);
    chk("c_rgb_slot0", rgb_out, 12'hF00);
    wr(1, 128, 0); v_x = 110; v_y = 10; step;   // E8 takes expiring slot 0
    wr(0, 0, 0); step;                          // E9
    chk("c_reuse_on", explosion_on, 1);
    chk("c_reuse_prio", rgb_out, 12'hFF0);
    chk("c_ac_reuse", active_count, 4);
    step(2);                                    // E11
    wr(1, 200, 200); step;                      // E12
    wr(1, 400, 400); step;                      // E13
    wr(0, 0, 0);
    v_x = 110; v_y = 10; b_x = 130; b_y = 10; step;  // E14
    chk("d_ac3", active_count, 3);
    chk("d_on", explosion_on, 1);
    chk("d_hit", bomberman_hit, 1);
    chk("d_ovf", overflow, 1);

    // Async reset mid-explosion
    Reset = 1'b1; #1;
    chk("d_rst_on", explosion_on, 0);
    chk("d_rst_rgb", rgb_out, 12'h000);
    chk("d_rst_hit", bomberman_hit, 0);
    chk("d_rst_ac", active_count, 0);
    chk("d_rst_ovf", overflow, 0);
    #20;
    Reset = 1'b0;
    step(2);
    chk("d_post_on", explosion_on, 0);
    chk("d_post_hit", bomberman_hit, 0);
    chk("d_post_ac", active_count, 0);
    v_x = 210; v_y = 210; step;
    chk("d_post_on2", explosion_on, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
